// File: rtl/lcd_pkg.sv
// Shared types, default timing and ROM tables for the 4-bit LCD bus sequencer.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWR_WAIT,
    ST_INIT_NIB,
    ST_CFG,
    ST_IDLE,
    ST_BYTE
  } seq_state_e;

  typedef enum logic [2:0] {
    NB_IDLE,
    NB_SETUP,
    NB_STROBE,
    NB_HOLD,
    NB_WAIT
  } nib_state_e;

  typedef enum logic [2:0] {
    DLY_NIB,
    DLY_CMD,
    DLY_LONG,
    DLY_INIT1,
    DLY_INIT2
  } dly_sel_e;

  localparam int T_SETUP_DEF = 2;
  localparam int T_E_DEF     = 12;
  localparam int T_HOLD_DEF  = 1;
  localparam int T_NIB_DEF   = 50;
  localparam int T_CMD_DEF   = 2000;
  localparam int T_LONG_DEF  = 82000;
  localparam int T_PWR_DEF   = 750000;
  localparam int T_INIT1_DEF = 205000;
  localparam int T_INIT2_DEF = 5000;
  localparam int CNT_W_DEF   = 20;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  function automatic logic [3:0] init_nib(input logic [1:0] idx);
    case (idx)
      2'd0, 2'd1, 2'd2: return 4'h3;
      default:          return 4'h2;
    endcase
  endfunction

  function automatic dly_sel_e init_dly(input logic [1:0] idx);
    case (idx)
      2'd0:    return DLY_INIT1;
      2'd1:    return DLY_INIT2;
      default: return DLY_CMD;
    endcase
  endfunction

  function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h28;
      2'd1:    return 8'h06;
      2'd2:    return 8'h0C;
      default: return 8'h01;
    endcase
  endfunction

  // Clear/home (and 0x03, which the controller also decodes as home) need the long wait.
  function automatic dly_sel_e post_dly(input logic rs, input logic [7:0] b);
    if (!rs && (b == CMD_CLEAR || b == CMD_HOME || b == 8'h03)) return DLY_LONG;
    return DLY_CMD;
  endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// Nibble engine: setup, enable strobe, hold, then a selectable post-delay.
// state     | meaning
// NB_IDLE   | no nibble in flight, outputs hold last value
// NB_SETUP  | rs/data driven, lcd_e low
// NB_STROBE | lcd_e high
// NB_HOLD   | lcd_e low, rs/data unchanged
// NB_WAIT   | post-nibble delay; done on last cycle
module lcd_nibble_tx
  import lcd_pkg::*;
#(
  parameter int T_SETUP = T_SETUP_DEF,
  parameter int T_E     = T_E_DEF,
  parameter int T_HOLD  = T_HOLD_DEF,
  parameter int T_NIB   = T_NIB_DEF,
  parameter int T_CMD   = T_CMD_DEF,
  parameter int T_LONG  = T_LONG_DEF,
  parameter int T_INIT1 = T_INIT1_DEF,
  parameter int T_INIT2 = T_INIT2_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       rs_i,
  input  logic [3:0] nib_i,
  input  logic [2:0] sel_i,
  output logic       done_o,
  output logic       lcd_rs_o,
  output logic       lcd_e_o,
  output logic [3:0] data_o
);

  nib_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, wait_m1;
  dly_sel_e         sel_q, sel_d;
  logic             rs_q, rs_d;
  logic             e_q, e_d;
  logic [3:0]       data_q, data_d;
  logic             cnt_zero;
  logic             take;

  assign cnt_zero = (cnt_q == '0);
  assign done_o   = (state_q == NB_WAIT) && cnt_zero;
  // A new nibble may chain directly off the last wait cycle of the previous one.
  assign take     = start_i && ((state_q == NB_IDLE) || done_o);

  always_comb begin
    case (sel_q)
      DLY_NIB:   wait_m1 = CNT_W'(T_NIB - 1);
      DLY_LONG:  wait_m1 = CNT_W'(T_LONG - 1);
      DLY_INIT1: wait_m1 = CNT_W'(T_INIT1 - 1);
      DLY_INIT2: wait_m1 = CNT_W'(T_INIT2 - 1);
      default:   wait_m1 = CNT_W'(T_CMD - 1);
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    rs_d    = rs_q;
    data_d  = data_q;
    case (state_q)
      NB_SETUP: begin
        if (cnt_zero) begin
          state_d = NB_STROBE;
          cnt_d   = CNT_W'(T_E - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      NB_STROBE: begin
        if (cnt_zero) begin
          state_d = NB_HOLD;
          cnt_d   = CNT_W'(T_HOLD - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      NB_HOLD: begin
        if (cnt_zero) begin
          state_d = NB_WAIT;
          cnt_d   = wait_m1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      NB_WAIT: begin
        if (cnt_zero) state_d = NB_IDLE;
        else          cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = NB_IDLE;
    endcase
    if (take) begin
      state_d = NB_SETUP;
      cnt_d   = CNT_W'(T_SETUP - 1);
      sel_d   = dly_sel_e'(sel_i);
      rs_d    = rs_i;
      data_d  = nib_i;
    end
    e_d = (state_d == NB_STROBE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= NB_IDLE;
      cnt_q   <= '0;
      sel_q   <= DLY_NIB;
      rs_q    <= 1'b0;
      e_q     <= 1'b0;
      data_q  <= 4'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      rs_q    <= rs_d;
      e_q     <= e_d;
      data_q  <= data_d;
    end
  end

  assign lcd_rs_o = rs_q;
  assign lcd_e_o  = e_q;
  assign data_o   = data_q;

endmodule

// File: rtl/lcd_bus_sequencer.sv
// Write-only 4-bit LCD bus sequencer: power-on init, configuration, then processor byte writes.
// state       | meaning
// ST_PWR_WAIT | power-on delay before first init nibble
// ST_INIT_NIB | sending the four single init nibbles
// ST_CFG      | sending the four configuration bytes
// ST_IDLE     | init complete, waiting for a processor byte
// ST_BYTE     | user byte in flight (high then low nibble)
module lcd_bus_sequencer
  import lcd_pkg::*;
#(
  parameter int T_SETUP = T_SETUP_DEF,
  parameter int T_E     = T_E_DEF,
  parameter int T_HOLD  = T_HOLD_DEF,
  parameter int T_NIB   = T_NIB_DEF,
  parameter int T_CMD   = T_CMD_DEF,
  parameter int T_LONG  = T_LONG_DEF,
  parameter int T_PWR   = T_PWR_DEF,
  parameter int T_INIT1 = T_INIT1_DEF,
  parameter int T_INIT2 = T_INIT2_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       init_done,
  output logic       lcd_rs,
  output logic       lcd_w,
  output logic       lcd_e,
  output logic [3:0] data
);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] pwr_cnt_q, pwr_cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             lo_q, lo_d;
  logic [7:0]       byte_q, byte_d;
  logic             brs_q, brs_d;
  logic             init_done_q, init_done_d;
  logic             ready_q, ready_d;

  logic             accept;
  logic             tx_start, tx_rs, tx_done;
  logic [3:0]       tx_nib;
  dly_sel_e         tx_sel;
  logic [7:0]       cfg_cur, cfg_nxt, cfg_first;

  assign accept = ready_q && req_valid;

  always_comb begin
    state_d   = state_q;
    pwr_cnt_d = pwr_cnt_q;
    idx_d     = idx_q;
    lo_d      = lo_q;
    byte_d    = byte_q;
    brs_d     = brs_q;
    tx_start  = 1'b0;
    tx_rs     = 1'b0;
    tx_nib    = 4'h0;
    tx_sel    = DLY_NIB;
    cfg_cur   = cfg_byte(idx_q);
    cfg_nxt   = cfg_byte(idx_q + 2'd1);
    cfg_first = cfg_byte(2'd0);
    // Ready/init_done trail IDLE entry by one cycle so both rise together.
    init_done_d = init_done_q | (state_q == ST_IDLE);
    ready_d     = (state_q == ST_IDLE) && !accept;

    case (state_q)
      ST_PWR_WAIT: begin
        if (pwr_cnt_q == '0) begin
          tx_start = 1'b1;
          tx_nib   = init_nib(2'd0);
          tx_sel   = init_dly(2'd0);
          idx_d    = 2'd0;
          state_d  = ST_INIT_NIB;
        end else begin
          pwr_cnt_d = pwr_cnt_q - CNT_W'(1);
        end
      end
      ST_INIT_NIB: begin
        if (tx_done) begin
          tx_start = 1'b1;
          if (idx_q == 2'd3) begin
            tx_nib  = cfg_first[7:4];
            tx_sel  = DLY_NIB;
            idx_d   = 2'd0;
            lo_d    = 1'b0;
            state_d = ST_CFG;
          end else begin
            tx_nib = init_nib(idx_q + 2'd1);
            tx_sel = init_dly(idx_q + 2'd1);
            idx_d  = idx_q + 2'd1;
          end
        end
      end
      ST_CFG: begin
        if (tx_done) begin
          if (!lo_q) begin
            tx_start = 1'b1;
            tx_nib   = cfg_cur[3:0];
            tx_sel   = post_dly(1'b0, cfg_cur);
            lo_d     = 1'b1;
          end else if (idx_q == 2'd3) begin
            state_d = ST_IDLE;
          end else begin
            tx_start = 1'b1;
            tx_nib   = cfg_nxt[7:4];
            tx_sel   = DLY_NIB;
            idx_d    = idx_q + 2'd1;
            lo_d     = 1'b0;
          end
        end
      end
      ST_IDLE: begin
        if (accept) begin
          byte_d   = req_data;
          brs_d    = req_rs;
          tx_start = 1'b1;
          tx_rs    = req_rs;
          tx_nib   = req_data[7:4];
          tx_sel   = DLY_NIB;
          lo_d     = 1'b0;
          state_d  = ST_BYTE;
        end
      end
      ST_BYTE: begin
        if (tx_done) begin
          if (!lo_q) begin
            tx_start = 1'b1;
            tx_rs    = brs_q;
            tx_nib   = byte_q[3:0];
            tx_sel   = post_dly(brs_q, byte_q);
            lo_d     = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_PWR_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_PWR_WAIT;
      pwr_cnt_q   <= CNT_W'(T_PWR - 1);
      idx_q       <= 2'd0;
      lo_q        <= 1'b0;
      byte_q      <= 8'h00;
      brs_q       <= 1'b0;
      init_done_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pwr_cnt_q   <= pwr_cnt_d;
      idx_q       <= idx_d;
      lo_q        <= lo_d;
      byte_q      <= byte_d;
      brs_q       <= brs_d;
      init_done_q <= init_done_d;
      ready_q     <= ready_d;
    end
  end

  lcd_nibble_tx #(
    .T_SETUP (T_SETUP),
    .T_E     (T_E),
    .T_HOLD  (T_HOLD),
    .T_NIB   (T_NIB),
    .T_CMD   (T_CMD),
    .T_LONG  (T_LONG),
    .T_INIT1 (T_INIT1),
    .T_INIT2 (T_INIT2),
    .CNT_W   (CNT_W)
  ) u_nib_tx (
    .clk      (clk),
    .rst      (rst),
    .start_i  (tx_start),
    .rs_i     (tx_rs),
    .nib_i    (tx_nib),
    .sel_i    (tx_sel),
    .done_o   (tx_done),
    .lcd_rs_o (lcd_rs),
    .lcd_e_o  (lcd_e),
    .data_o   (data)
  );

  assign req_ready = ready_q;
  assign init_done = init_done_q;
  assign lcd_w     = 1'b0;

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Directed bench for lcd_bus_sequencer with small timing parameters.
module tb_lcd_bus_sequencer;

  localparam int TS = 2, TE = 3, TH = 1, TN = 4, TC = 10, TL = 30;
  localparam int TP = 20, TI1 = 15, TI2 = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_rs = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       req_ready, init_done, lcd_rs, lcd_w, lcd_e;
  logic [3:0] data;

  always #5 clk = ~clk;

  lcd_bus_sequencer #(
    .T_SETUP(TS), .T_E(TE), .T_HOLD(TH), .T_NIB(TN), .T_CMD(TC), .T_LONG(TL),
    .T_PWR(TP), .T_INIT1(TI1), .T_INIT2(TI2), .CNT_W(20)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_rs    (req_rs),
    .req_data  (req_data),
    .req_ready (req_ready),
    .init_done (init_done),
    .lcd_rs    (lcd_rs),
    .lcd_w     (lcd_w),
    .lcd_e     (lcd_e),
    .data      (data)
  );

  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Strobe recorder: one entry per lcd_e rising edge.
  int         n_rise = 0;
  int         rise_cyc [128];
  logic [3:0] rise_dat [128];
  logic       rise_rs  [128];
  int         rise_set [128];
  int         rise_w   [128];
  int         glitches = 0;
  logic       prev_e = 1'b0, prev_rs = 1'b0;
  logic [3:0] prev_d = 4'h0;
  int         last_chg = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_e   <= 1'b0;
      prev_d   <= 4'h0;
      prev_rs  <= 1'b0;
      last_chg <= 0;
    end else begin
      if (data !== prev_d || lcd_rs !== prev_rs) begin
        last_chg <= cyc;
        if (lcd_e && prev_e) glitches <= glitches + 1;
      end
      if (lcd_e && !prev_e) begin
        rise_cyc[n_rise] <= cyc;
        rise_dat[n_rise] <= data;
        rise_rs[n_rise]  <= lcd_rs;
        rise_set[n_rise] <= (data !== prev_d || lcd_rs !== prev_rs) ? 0 : cyc - last_chg;
        n_rise           <= n_rise + 1;
      end
      if (!lcd_e && prev_e && n_rise > 0) rise_w[n_rise-1] <= cyc - rise_cyc[n_rise-1];
      prev_e  <= lcd_e;
      prev_d  <= data;
      prev_rs <= lcd_rs;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Hand-computed power-up schedule (cycles after reset release).
  int pu_rise [12] = '{22, 43, 57, 73, 89, 99, 115, 125, 141, 151, 167, 177};
  int pu_dat  [12] = '{3, 3, 3, 2, 2, 8, 0, 6, 0, 12, 0, 1};

  task automatic powerup_seq(input string tag);
    int base, k;
    base = n_rise;
    k = 0;
    while (n_rise < base + 12 && k < 400) begin @(negedge clk); k++; end
    k = 0;
    while (!init_done && k < 200) begin @(negedge clk); k++; end
    check({tag, "_init_done_cyc"}, cyc, 212);
    check({tag, "_ready_with_done"}, req_ready, 1);
    check({tag, "_strobe_count"}, n_rise - base, 12);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("%s_dat%0d", tag, i), rise_dat[base+i], pu_dat[i]);
      check($sformatf("%s_rs%0d", tag, i), rise_rs[base+i], 0);
      check($sformatf("%s_rise%0d", tag, i), rise_cyc[base+i], pu_rise[i]);
      check($sformatf("%s_width%0d", tag, i), rise_w[base+i], TE);
      check($sformatf("%s_setup%0d", tag, i), int'(rise_set[base+i] >= TS), 1);
    end
  endtask

  task automatic send_byte(input logic rs, input logic [7:0] d, output int acc);
    int k;
    req_rs    = rs;
    req_data  = d;
    req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 300) begin @(negedge clk); k++; end
    check("ready_before_accept", req_ready, 1);
    @(posedge clk);
    #1;
    acc = cyc;
    req_valid = 1'b0;
  endtask

  task automatic byte_xfer(input string tag, input logic rs, input logic [7:0] d,
                           input int exp_lat, output int acc);
    int base, k;
    base = n_rise;
    send_byte(rs, d, acc);
    check({tag, "_ready_low_after_accept"}, req_ready, 0);
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 300) begin @(negedge clk); k++; end
    check({tag, "_latency"}, cyc - acc, exp_lat);
    check({tag, "_strobes"}, n_rise - base, 2);
    check({tag, "_hi_dat"}, rise_dat[base], int'(d[7:4]));
    check({tag, "_lo_dat"}, rise_dat[base+1], int'(d[3:0]));
    check({tag, "_hi_rs"}, rise_rs[base], int'(rs));
    check({tag, "_lo_rs"}, rise_rs[base+1], int'(rs));
    check({tag, "_hi_rise"}, rise_cyc[base] - acc, TS);
    check({tag, "_lo_rise"}, rise_cyc[base+1] - acc, 12);
    check({tag, "_hi_width"}, rise_w[base], TE);
    check({tag, "_lo_width"}, rise_w[base+1], TE);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int acc, a1, a2, base, k;

    repeat (3) @(negedge clk);
    check("rst_lcd_e", lcd_e, 0);
    check("rst_lcd_rs", lcd_rs, 0);
    check("rst_lcd_w", lcd_w, 0);
    check("rst_data", data, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_init_done", init_done, 0);

    // Early request held during init; must wait for init_done and go out once.
    req_rs    = 1'b1;
    req_data  = 8'h41;
    req_valid = 1'b1;
    rst = 1'b0;
    powerup_seq("pu1");
    byte_xfer("char41", 1'b1, 8'h41, 27, acc);
    check("early_accept_cyc", acc, 213);

    byte_xfer("clear_rs0", 1'b0, 8'h01, 47, acc);
    byte_xfer("clear_rs1", 1'b1, 8'h01, 27, acc);
    byte_xfer("home_rs0", 1'b0, 8'h02, 47, acc);
    byte_xfer("cmd03_rs0", 1'b0, 8'h03, 47, acc);
    byte_xfer("cmd04_rs0", 1'b0, 8'h04, 27, acc);
    byte_xfer("cmd00_rs0", 1'b0, 8'h00, 27, acc);

    // Back-to-back with req_valid held high.
    base      = n_rise;
    req_rs    = 1'b1;
    req_data  = 8'h48;
    req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 300) begin @(negedge clk); k++; end
    @(posedge clk);
    #1;
    a1 = cyc;
    req_data = 8'h49;
    k = 0;
    while (!req_ready && k < 300) begin @(negedge clk); k++; end
    @(posedge clk);
    #1;
    a2 = cyc;
    req_valid = 1'b0;
    k = 0;
    while (!req_ready && k < 300) begin @(negedge clk); k++; end
    check("b2b_accept_gap", a2 - a1, 28);
    check("b2b_strobes", n_rise - base, 4);
    check("b2b_dat0", rise_dat[base], 4);
    check("b2b_dat1", rise_dat[base+1], 8);
    check("b2b_dat2", rise_dat[base+2], 4);
    check("b2b_dat3", rise_dat[base+3], 9);
    check("b2b_rise0", rise_cyc[base] - a1, 2);
    check("b2b_rise1", rise_cyc[base+1] - a1, 12);
    check("b2b_rise2", rise_cyc[base+2] - a1, 30);
    check("b2b_rise3", rise_cyc[base+3] - a1, 40);
    check("b2b_final_latency", cyc - a2, 27);

    // Reset while lcd_e is high.
    send_byte(1'b1, 8'h55, acc);
    k = 0;
    while (!lcd_e && k < 50) begin @(negedge clk); k++; end
    check("pre_rst_lcd_e", lcd_e, 1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_lcd_e", lcd_e, 0);
    check("midrst_init_done", init_done, 0);
    check("midrst_req_ready", req_ready, 0);
    check("midrst_data", data, 0);
    check("midrst_lcd_rs", lcd_rs, 0);
    @(negedge clk);
    rst = 1'b0;
    powerup_seq("pu2");
    byte_xfer("post_rst_char", 1'b1, 8'h5A, 27, acc);

    check("no_glitch_while_e_high", glitches, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lcd_bus_sequencer.md
Name: lcd_bus_sequencer

Overview:
Write-only controller for the 4-bit character LCD bus (lcd_rs, lcd_w, lcd_e, data[3:0]) driven by the mini-processor.
- Runs the power-on initialisation sequence and configuration on its own.
- Accepts byte writes (command or character) from the processor over a valid/ready handshake.
- Splits each byte into two nibbles, generates the lcd_e strobe timing, and enforces the post-command execution delays.
- Sits between the processor and the LCD pins, and replaces the ad-hoc pin driving inside the processor.

Parameters:
- T_SETUP, 2: cycles that rs/data are stable before lcd_e rises.
- T_E, 12: cycles that lcd_e is held high.
- T_HOLD, 1: cycles that rs/data are held after lcd_e falls.
- T_NIB, 50: gap cycles between the high and low nibble of one byte (1 us at 50 MHz).
- T_CMD, 2000: wait after a normal byte (40 us).
- T_LONG, 82000: wait after clear/home commands (1.64 ms).
- T_PWR, 750000: power-on wait before the first init nibble (15 ms).
- T_INIT1, 205000: wait after the first 0x3 init nibble (4.1 ms).
- T_INIT2, 5000: wait after the second 0x3 init nibble (100 us).
- CNT_W, 20: width of the delay counter; must hold the largest T_* value.

Ports:
- clk, input, 1: system clock, 50 MHz.
- rst, input, 1: asynchronous, active-high reset.
- req_valid, input, 1: processor has a byte to write.
- req_rs, input, 1: 0 = command, 1 = data/character.
- req_data, input, 8: byte to write.
- req_ready, output, 1: sequencer can accept a byte this cycle.
- init_done, output, 1: init and configuration sequence complete.
- lcd_rs, output, 1: LCD register select.
- lcd_w, output, 1: LCD read/write; tied 0 (write only).
- lcd_e, output, 1: LCD enable strobe.
- data, output, 4: LCD data nibble.

Behaviour:
- Reset values: lcd_e=0, lcd_rs=0, lcd_w=0, data=0, req_ready=0, init_done=0. The state machine enters PWR_WAIT with the counter loaded to T_PWR.
- Reset asserted mid-operation aborts immediately: lcd_e drops asynchronously, the in-flight byte is discarded, and the full init sequence reruns.
- States: PWR_WAIT, INIT_NIB, CFG, IDLE, SETUP, STROBE, HOLD, WAIT.
- The nibble engine SETUP -> STROBE -> HOLD -> WAIT is shared by init, configuration and user bytes.
  - SETUP: drives rs/data for T_SETUP cycles with lcd_e=0.
  - STROBE: lcd_e=1 for T_E cycles.
  - HOLD: lcd_e=0 with rs/data unchanged for T_HOLD cycles.
  - WAIT: counts the selected delay.
- Init nibbles, all with rs=0, sent as single nibbles (no low nibble):
  - 0x3, then wait T_INIT1.
  - 0x3, then wait T_INIT2.
  - 0x3, then wait T_CMD.
  - 0x2, then wait T_CMD.
- CFG: four configuration bytes with rs=0, in order: 0x28, 0x06, 0x0C, 0x01.
  - 0x01 waits T_LONG.
  - After its wait: init_done=1 (held until reset), state -> IDLE.
- IDLE:
  - req_ready=1 only in IDLE with init_done=1.
  - Accept on the clk edge where req_valid and req_ready are both 1: latch req_rs/req_data, req_ready=0 on the next cycle.
  - req_valid while not ready is ignored. The processor must hold the request until it is accepted.
- Byte transfer:
  - High nibble req_data[7:4] first, then a T_NIB gap, then low nibble [3:0] through the same engine.
  - After the low nibble, wait T_LONG if rs=0 and data is 0x01, 0x02 or 0x03; otherwise wait T_CMD.
  - Then back to IDLE, req_ready=1.
- Latency:
  - From the accept edge, lcd_e first rises T_SETUP cycles later.
  - req_ready reasserts exactly 2*(T_SETUP+T_E+T_HOLD)+T_NIB+T_post+1 cycles after the accept edge. T_post is T_CMD or T_LONG.
- Counter:
  - Loads (T-1) on state entry and decrements to 0. The state exits on the cycle the counter reads 0.
  - Every T_* must be >=1. No wrap-around is possible.
- data and lcd_rs are registered outputs: no glitches while lcd_e=1. data holds its last value in IDLE.

Decomposition:
- Package lcd_pkg holds:
  - state encoding;
  - default timing constants;
  - the init nibble ROM {3,3,3,2} and its wait-select table;
  - the config byte ROM {28,06,0C,01};
  - named command constants CLEAR=0x01, HOME=0x02.
- One natural sub-module, lcd_nibble_tx:
  - Takes start, rs, nibble and a post-delay select.
  - Drives lcd_rs/lcd_e/data and returns done.
  - The top FSM sequences it for init, config and user bytes.

Test Plan:
All scenarios use small parameters: T_SETUP=2, T_E=3, T_HOLD=1, T_NIB=4, T_CMD=10, T_LONG=30, T_PWR=20, T_INIT1=15, T_INIT2=8.
1. Power-up: release rst at cycle 0 -> no lcd_e for 20 cycles; then 4 single-nibble strobes with data 3,3,3,2 at rs=0, each lcd_e high exactly 3 cycles. Then 8 strobes of config nibbles 2,8,0,6,0,C,0,1. init_done rises after the 30-cycle wait following the final nibble 1, and req_ready rises with it.
2. Character write: rs=1, data=0x41 accepted -> strobes with data=4 then data=1, lcd_rs=1 throughout. req_ready returns 2*6+4+10+1=27 cycles after the accept edge.
3. Clear command: rs=0, data=0x01 -> post-wait 30 cycles. req_ready returns 47 cycles after accept. The same byte with rs=1 returns after 27 cycles.
4. Back-to-back: req_valid held high with 0x48 then 0x49 -> second byte accepted only on the edge req_ready is 1. Nibble sequence 4,8,4,9 with no overlap.
5. Early request: req_valid=1 during init -> ignored until init_done. The byte is then sent exactly once.
6. Reset mid-strobe: rst asserted while lcd_e=1 -> lcd_e=0 the same cycle (asynchronous), init_done=0, req_ready=0. After release the full power-up sequence of scenario 1 repeats.
